// File: rtl/pulse_arb_pkg.sv
// pulse_arb_pkg: shared sizes and FSM encoding for the pulse arbiter
package pulse_arb_pkg;
  localparam int N_CH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_e;
endpackage

// File: rtl/pulse_pend_ch.sv
// pulse_pend_ch: per-channel rising-edge detect, saturating pending counter and sticky drop flag
module pulse_pend_ch
  import pulse_arb_pkg::*;
#(
  parameter int CNT_W = pulse_arb_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_i,
  input  logic             acc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             drop_o
);
  logic             prev_q, drop_q, drop_d, rise, sat;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    rise   = in_i & ~prev_q;
    sat    = cnt_q == CNT_W'(CNT_MAX);
    // a rise coinciding with an accept cancels out: no count change, no drop
    cnt_d  = (rise && !acc_i) ? (sat ? cnt_q : cnt_q + 1'b1) :
             (acc_i && !rise) ? cnt_q - 1'b1 : cnt_q;
    drop_d = drop_q | (rise & ~acc_i & sat);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      prev_q <= in_i;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  assign cnt_o  = cnt_q;
  assign drop_o = drop_q;
endmodule

// File: rtl/pulse_arbiter.sv
// pulse_arbiter: counts input pulses per channel and offers them one at a time in round-robin order
module pulse_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int N_CH  = pulse_arb_pkg::N_CH,
  parameter int CNT_W = pulse_arb_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  output logic            ev_valid,
  output logic [1:0]      ev_id,
  input  logic            ev_ready,
  output logic [N_CH-1:0] drop,
  output logic            busy
);
  localparam int ID_W = $clog2(N_CH);
  state_e           state_q;
  logic [ID_W-1:0]  id_q, last_q, nxt, idx;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  nz;
  logic             accept;
  assign accept = (state_q == OFFER) & ev_ready;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_pend_ch #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (in[i]),
      .acc_i (accept && (id_q == ID_W'(i))),
      .cnt_o (cnt[i]),
      .drop_o(drop[i])
    );
    assign nz[i] = |cnt[i];
  end
  // walk downward so the closest channel after last_q is the final assignment
  always_comb begin
    nxt = last_q;
    idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = ID_W'((int'(last_q) + k) % N_CH);
      nxt = nz[idx] ? idx : nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      last_q  <= ID_W'(N_CH - 1);
    end else if (state_q == IDLE) begin
      if (|nz) begin
        state_q <= OFFER;
        id_q    <= nxt;
      end
    end else if (ev_ready) begin
      state_q <= IDLE;
      last_q  <= id_q;
    end
  assign ev_valid = state_q == OFFER;
  assign ev_id    = 2'(id_q);
  assign busy     = ev_valid | (|nz);
endmodule

// File: tb/tb_pulse_arbiter.sv
// tb_pulse_arbiter: scoreboard bench comparing the arbiter to a count-based reference model
module tb_pulse_arbiter;
  typedef struct {bit v; int id; logic [3:0] dr; bit bz;} exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, ev_ready = 1'b0, ev_valid, busy;
  logic [3:0] in = '0, drop;
  logic [1:0] ev_id;
  exp_t       sb[$];
  int         n_vec = 0, n_err = 0;
  int         pend[4];
  bit         prv[4];
  bit         m_off;
  int         m_id, m_last;
  logic [3:0] m_drop;

  pulse_arbiter dut (
    .clk(clk), .rst_n(rst_n), .in(in), .ev_valid(ev_valid), .ev_id(ev_id),
    .ev_ready(ev_ready), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void mreset();
    foreach (pend[i]) begin
      pend[i] = 0;
      prv[i]  = 1'b0;
    end
    m_off  = 1'b0;
    m_id   = 0;
    m_last = 3;
    m_drop = '0;
  endfunction

  function automatic bit mbusy();
    int s = 0;
    foreach (pend[i]) s += pend[i];
    return m_off || s > 0;
  endfunction

  // one clock edge of the spec rules: count rises, retire accepts, round-robin pick from old counts
  function automatic void mstep(logic [3:0] iv, bit rdy);
    int old[4];
    bit acc, r, a;
    old = pend;
    acc = m_off && rdy;
    for (int i = 0; i < 4; i++) begin
      r = iv[i] && !prv[i];
      a = acc && m_id == i;
      if (r && !a) begin
        if (pend[i] == 3) m_drop[i] = 1'b1;
        else pend[i]++;
      end else if (a && !r) pend[i]--;
      prv[i] = iv[i];
    end
    if (!m_off) begin
      for (int k = 1; k <= 4; k++) begin
        if (old[(m_last + k) % 4] > 0) begin
          m_off = 1'b1;
          m_id  = (m_last + k) % 4;
          break;
        end
      end
    end else if (acc) begin
      m_off  = 1'b0;
      m_last = m_id;
    end
  endfunction

  task automatic step(input logic [3:0] iv, input bit rdy, input bit rst);
    exp_t e;
    @(posedge clk);
    #2;
    in       = iv;
    ev_ready = rdy;
    rst_n    = !rst;
    if (rst) begin
      mreset();
      #1;
      chk("rst_valid", 32'(ev_valid), 32'(0));
      chk("rst_drop", 32'(drop), 32'(0));
    end
    e.v  = m_off;
    e.id = m_id;
    e.dr = m_drop;
    e.bz = mbusy();
    sb.push_back(e);
    if (!rst) mstep(iv, rdy);
  endtask

  task automatic run(input logic [3:0] iv, input bit rdy, input int n);
    for (int j = 0; j < n; j++) step(iv, rdy, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ev_valid", 32'(ev_valid), 32'(e.v));
      if (e.v) chk("ev_id", 32'(ev_id), 32'(e.id));
      chk("drop", 32'(drop), 32'(e.dr));
      chk("busy", 32'(busy), 32'(e.bz));
    end
  end

  initial begin
    mreset();
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    run(4'b0001, 1'b1, 8);
    step(4'b0000, 1'b0, 1'b1);
    run(4'b0000, 1'b1, 1);
    run(4'b1111, 1'b1, 12);
    step(4'b0000, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      run(4'b0100, 1'b0, 1);
      run(4'b0000, 1'b0, 1);
    end
    run(4'b0000, 1'b1, 10);
    step(4'b0000, 1'b0, 1'b1);
    run(4'b0010, 1'b0, 1);
    run(4'b0000, 1'b0, 2);
    run(4'b0010, 1'b1, 6);
    step(4'b0000, 1'b0, 1'b1);
    run(4'b0001, 1'b1, 4);
    run(4'b0000, 1'b0, 1);
    run(4'b1001, 1'b0, 3);
    run(4'b1001, 1'b1, 8);
    step(4'b0000, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      run(4'b0101, 1'b0, 1);
      run(4'b0000, 1'b0, 1);
    end
    step(4'b0000, 1'b0, 1'b1);
    run(4'b0000, 1'b1, 6);
    step(4'b0001, 1'b0, 1'b1);
    run(4'b0001, 1'b1, 8);
    for (int j = 0; j < 2000; j++)
      step(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    run(4'b0000, 1'b1, 30);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
